// File: rtl/lcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_pkg                                                                    |
// | Shared constants, FSM encoding and colour helper for the LCD pattern path. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lcd_pkg;

    localparam int H_DISP = 800;
    localparam int V_DISP = 480;

    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] BLACK = 16'h0000;
    localparam logic [15:0] RED   = 16'hF800;
    localparam logic [15:0] GREEN = 16'h07E0;
    localparam logic [15:0] BLUE  = 16'h001F;

    localparam logic [2:0] PAT_BARS    = 3'd0;
    localparam logic [2:0] PAT_CHECKER = 3'd1;
    localparam logic [2:0] PAT_SOLID   = 3'd2;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        RUN        = 2'd1,
        PENDING    = 2'd2
    } fsm_state_t;

    // Solid-colour cycle: white -> red -> green -> blue -> black -> white.
    function automatic logic [15:0] next_solid(input logic [15:0] cur);
        case (cur)
            WHITE:   next_solid = RED;
            RED:     next_solid = GREEN;
            GREEN:   next_solid = BLUE;
            BLUE:    next_solid = BLACK;
            default: next_solid = WHITE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_pattern_ctrl_key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_debounce                                                               |
// | 2-flop synchronizer, saturating stability counter, one-cycle press pulse.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module key_debounce #(
    parameter logic [19:0] DEBOUNCE_CYC = 20'd660000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_evt
);

    logic        sync_q1;
    logic        sync_q2;
    logic        stable;
    logic [19:0] stable_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1    <= 1'b1;
            sync_q2    <= 1'b1;
            stable     <= 1'b1;
            stable_cnt <= 20'd0;
            key_evt    <= 1'b0;
        end else begin
            sync_q1 <= key_n;
            sync_q2 <= sync_q1;
            // sync_q1 != sync_q2 means sync_q2 is about to change level
            if (sync_q1 != sync_q2)
                stable_cnt <= 20'd0;
            else if (stable_cnt != DEBOUNCE_CYC)
                stable_cnt <= stable_cnt + 20'd1;
            if (stable_cnt == DEBOUNCE_CYC)
                stable <= sync_q2;
            key_evt <= (stable_cnt == DEBOUNCE_CYC) && stable && !sync_q2;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_pattern_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_pattern_ctrl                                                           |
// | Frame-aligned test-pattern sequencer (key / auto advance).                 |
// | Optional macro LCD_PATTERN_REVERSE_EN adds key_prev_n for backward steps.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lcd_pattern_ctrl
    import lcd_pkg::*;
#(
    parameter int          NUM_PATTERNS   = 3,
    parameter logic [19:0] DEBOUNCE_CYC   = 20'd660000,
    parameter logic [7:0]  FRAMES_PER_PAT = 8'd120,
    parameter logic [6:0]  CHECKER_DEF    = 7'd40
) (
    input  logic        lcd_clk,
    input  logic        sys_rst_n,
    input  logic        frame_start,
    input  logic        key_n,
`ifdef LCD_PATTERN_REVERSE_EN
    input  logic        key_prev_n,
`endif
    input  logic        auto_en,
    output logic [2:0]  pattern_sel,
    output logic [6:0]  checker_size,
    output logic [15:0] solid_color,
    output logic        pattern_chg
);

    localparam logic [2:0] LAST_PAT = 3'(NUM_PATTERNS - 1);

    fsm_state_t  state;
    fsm_state_t  state_nxt;
    logic        req_back;
    logic        req_back_nxt;
    logic        commit;
    logic        key_evt;
    logic        back_evt;
    logic        auto_evt;
    logic        fwd_evt;
    logic [7:0]  frame_cnt;
    logic [2:0]  next_pat;
    logic        checker_half;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_fwd (
        .clk     (lcd_clk),
        .rst_n   (sys_rst_n),
        .key_n   (key_n),
        .key_evt (key_evt)
    );

`ifdef LCD_PATTERN_REVERSE_EN
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_back (
        .clk     (lcd_clk),
        .rst_n   (sys_rst_n),
        .key_n   (key_prev_n),
        .key_evt (back_evt)
    );
`else
    assign back_evt = 1'b0;
`endif

    // Event fires on the frame_start that brings the count up to FRAMES_PER_PAT-1.
    assign auto_evt = frame_start && auto_en && ((frame_cnt + 8'd1) == (FRAMES_PER_PAT - 8'd1));
    assign fwd_evt  = key_evt || auto_evt;

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            frame_cnt <= 8'd0;
        else if (!auto_en || commit)
            frame_cnt <= 8'd0;
        else if (frame_start && (frame_cnt != FRAMES_PER_PAT - 8'd1))
            frame_cnt <= frame_cnt + 8'd1;
    end

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= WAIT_FRAME;
            req_back <= 1'b0;
        end else begin
            state    <= state_nxt;
            req_back <= req_back_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        req_back_nxt = req_back;
        commit       = 1'b0;
        case (state)
            WAIT_FRAME: begin
                if (frame_start)
                    state_nxt = RUN;
            end
            RUN: begin
                // Simultaneous forward and backward requests cancel each other.
                if (fwd_evt != back_evt) begin
                    state_nxt    = PENDING;
                    req_back_nxt = back_evt;
                end
            end
            PENDING: begin
                if (frame_start) begin
                    commit    = 1'b1;
                    state_nxt = RUN;
                end else if (fwd_evt && back_evt) begin
                    state_nxt = RUN;
                end else if (fwd_evt) begin
                    req_back_nxt = 1'b0;
                end else if (back_evt) begin
                    req_back_nxt = 1'b1;
                end
            end
            default: state_nxt = WAIT_FRAME;
        endcase
    end

    always_comb begin
        next_pat = 3'd0;
        if (req_back)
            next_pat = (pattern_sel == 3'd0) ? LAST_PAT : pattern_sel - 3'd1;
        else
            next_pat = (pattern_sel == LAST_PAT) ? 3'd0 : pattern_sel + 3'd1;
    end

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pattern_sel  <= PAT_BARS;
            checker_size <= CHECKER_DEF;
            solid_color  <= WHITE;
            pattern_chg  <= 1'b0;
            checker_half <= 1'b0;
        end else begin
            pattern_chg <= commit;
            if (commit) begin
                pattern_sel <= next_pat;
                if (next_pat == PAT_CHECKER) begin
                    checker_size <= checker_half ? (CHECKER_DEF >> 1) : CHECKER_DEF;
                    checker_half <= !checker_half;
                end
                if (next_pat == PAT_SOLID)
                    solid_color <= next_solid(solid_color);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_pattern_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lcd_pattern_ctrl                                                        |
// | Directed self-checking bench for the pattern sequencer.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lcd_pattern_ctrl;

    localparam int DEB = 2000;

    logic        lcd_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        key_n = 1'b1;
    logic        auto_en = 1'b0;
`ifdef LCD_PATTERN_REVERSE_EN
    logic        key_prev_n = 1'b1;
`endif
    logic [2:0]  pattern_sel;
    logic [6:0]  checker_size;
    logic [15:0] solid_color;
    logic        pattern_chg;

    int vectors = 0;
    int miscompares = 0;
    int chg_cnt = 0;
    int chg_base;

    lcd_pattern_ctrl #(
        .NUM_PATTERNS   (3),
        .DEBOUNCE_CYC   (20'd2000),
        .FRAMES_PER_PAT (8'd4),
        .CHECKER_DEF    (7'd40)
    ) dut (
        .lcd_clk      (lcd_clk),
        .sys_rst_n    (sys_rst_n),
        .frame_start  (frame_start),
        .key_n        (key_n),
`ifdef LCD_PATTERN_REVERSE_EN
        .key_prev_n   (key_prev_n),
`endif
        .auto_en      (auto_en),
        .pattern_sel  (pattern_sel),
        .checker_size (checker_size),
        .solid_color  (solid_color),
        .pattern_chg  (pattern_chg)
    );

    always #5 lcd_clk = ~lcd_clk;

    always @(negedge lcd_clk)
        if (pattern_chg) chg_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge lcd_clk);
        #1;
    endtask

    task automatic fs_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst_n   = 1'b0;
        frame_start = 1'b0;
        key_n       = 1'b1;
        auto_en     = 1'b0;
        repeat (3) tick();
        check("rst_sel", 32'(pattern_sel), 32'd0);
        check("rst_checker", 32'(checker_size), 32'd40);
        check("rst_solid", 32'(solid_color), 32'hFFFF);
        check("rst_chg", 32'(pattern_chg), 32'd0);
        sys_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        // Key held low before the first frame, committed at a later frame_start.
        do_reset();
        chg_base = chg_cnt;
        key_n = 1'b0;
        repeat (100) tick();
        check("t1_prefs_sel", 32'(pattern_sel), 32'd0);
        fs_pulse();
        check("t1_fs1_sel", 32'(pattern_sel), 32'd0);
        repeat (DEB + 10) tick();
        check("t1_pend_sel", 32'(pattern_sel), 32'd0);
        fs_pulse();
        check("t1_commit_sel", 32'(pattern_sel), 32'd1);
        check("t1_commit_chg", 32'(pattern_chg), 32'd1);
        check("t1_checker", 32'(checker_size), 32'd40);
        tick();
        check("t1_chg_drop", 32'(pattern_chg), 32'd0);
        key_n = 1'b1;
        repeat (DEB + 10) tick();
        check("t1_chg_count", 32'(chg_cnt - chg_base), 32'd1);

        // Bouncing key: only the final stable press counts.
        chg_base = chg_cnt;
        for (int i = 0; i < 5; i++) begin
            key_n = 1'b0;
            repeat (1000) tick();
            key_n = 1'b1;
            repeat (1000) tick();
        end
        fs_pulse();
        check("t2_bounce_sel", 32'(pattern_sel), 32'd1);
        key_n = 1'b0;
        repeat (DEB + 10) tick();
        fs_pulse();
        check("t2_sel", 32'(pattern_sel), 32'd2);
        check("t2_solid", 32'(solid_color), 32'hF800);
        repeat (5) tick();
        fs_pulse();
        fs_pulse();
        check("t2_hold_sel", 32'(pattern_sel), 32'd2);
        check("t2_chg_count", 32'(chg_cnt - chg_base), 32'd1);
        key_n = 1'b1;
        repeat (DEB + 10) tick();

        // Auto-advance every 4 frames, including colour / checker sequencing.
        do_reset();
        chg_base = chg_cnt;
        auto_en = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            fs_pulse();
            case (k)
                3:  check("t3_f3_sel", 32'(pattern_sel), 32'd0);
                4: begin
                    check("t3_f4_sel", 32'(pattern_sel), 32'd1);
                    check("t3_f4_chg", 32'(pattern_chg), 32'd1);
                    check("t3_f4_checker", 32'(checker_size), 32'd40);
                end
                7:  check("t3_f7_sel", 32'(pattern_sel), 32'd1);
                8: begin
                    check("t3_f8_sel", 32'(pattern_sel), 32'd2);
                    check("t3_f8_solid", 32'(solid_color), 32'hF800);
                end
                12: check("t3_f12_sel", 32'(pattern_sel), 32'd0);
                16: begin
                    check("t3_f16_sel", 32'(pattern_sel), 32'd1);
                    check("t3_f16_checker", 32'(checker_size), 32'd20);
                end
                20: check("t3_f20_solid", 32'(solid_color), 32'h07E0);
                32: begin
                    check("t3_f32_sel", 32'(pattern_sel), 32'd2);
                    check("t3_f32_solid", 32'(solid_color), 32'h001F);
                end
                default: ;
            endcase
            repeat (99) tick();
        end
        check("t3_chg_count", 32'(chg_cnt - chg_base), 32'd8);

        // Dropping auto_en mid-count prevents the advance.
        do_reset();
        chg_base = chg_cnt;
        auto_en = 1'b1;
        fs_pulse();
        repeat (99) tick();
        fs_pulse();
        repeat (10) tick();
        auto_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            repeat (99) tick();
            fs_pulse();
        end
        check("t3_drop_sel", 32'(pattern_sel), 32'd0);
        check("t3_drop_chg", 32'(chg_cnt - chg_base), 32'd0);

        // key_evt and auto_evt together, plus a second key_evt while pending.
        do_reset();
        chg_base = chg_cnt;
        auto_en = 1'b1;
        fs_pulse();
        repeat (20) tick();
        fs_pulse();
        repeat (20) tick();
        key_n = 1'b0;
        repeat (DEB + 3) tick();
        fs_pulse();
        check("t4_coinc_sel", 32'(pattern_sel), 32'd0);
        key_n = 1'b1;
        repeat (DEB + 10) tick();
        key_n = 1'b0;
        repeat (DEB + 10) tick();
        check("t4_pend_sel", 32'(pattern_sel), 32'd0);
        auto_en = 1'b0;
        fs_pulse();
        check("t4_commit_sel", 32'(pattern_sel), 32'd1);
        repeat (20) tick();
        fs_pulse();
        check("t4_next_sel", 32'(pattern_sel), 32'd1);
        check("t4_chg_count", 32'(chg_cnt - chg_base), 32'd1);
        key_n = 1'b1;
        repeat (DEB + 10) tick();

        // Asynchronous reset while a request is pending.
        key_n = 1'b0;
        repeat (DEB + 10) tick();
        key_n = 1'b1;
        sys_rst_n = 1'b0;
        #1;
        check("t6_async_sel", 32'(pattern_sel), 32'd0);
        check("t6_async_checker", 32'(checker_size), 32'd40);
        check("t6_async_solid", 32'(solid_color), 32'hFFFF);
        check("t6_async_chg", 32'(pattern_chg), 32'd0);
        tick();
        sys_rst_n = 1'b1;
        chg_base = chg_cnt;
        tick();
        fs_pulse();
        repeat (20) tick();
        fs_pulse();
        repeat (5) tick();
        check("t6_after_sel", 32'(pattern_sel), 32'd0);
        check("t6_after_chg", 32'(chg_cnt - chg_base), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
